// File: rtl/preg_ready_table.sv
// Physical-register readiness scoreboard: rename marks destinations busy, ALU
// wakeups mark them ready, and issue queries readiness with a same-cycle wake bypass.
module preg_ready_table #(
    parameter int FETCH_WIDTH = 2,
    parameter int WAKE_NUM    = 2,
    parameter int PREG_NUM    = 64,
    parameter int PREG_W      = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [FETCH_WIDTH-1:0]        alloc_valid,
    input  logic [FETCH_WIDTH*PREG_W-1:0] alloc_preg,
    input  logic [WAKE_NUM-1:0]           wake_valid,
    input  logic [WAKE_NUM*PREG_W-1:0]    wake_preg,
    input  logic                          flush,
    input  logic [FETCH_WIDTH*PREG_W-1:0] psrc1,
    input  logic [FETCH_WIDTH*PREG_W-1:0] psrc2,
    output logic [FETCH_WIDTH-1:0]        v1,
    output logic [FETCH_WIDTH-1:0]        v2,
    output logic [PREG_W:0]               busy_cnt
);

    localparam logic [PREG_W:0] PREG_LIMIT = (PREG_W+1)'(PREG_NUM);

    logic [PREG_NUM-1:0] r_ready;
    logic [PREG_W:0]     r_busy_cnt;
    logic [PREG_NUM-1:0] w_ready_next;
    logic [PREG_W:0]     w_busy_next;

    // Reads see the pre-edge table; a matching wake forces ready so issue can
    // select a consumer in the very cycle its producer broadcasts.
    function automatic logic lookup(
        input logic [PREG_W-1:0]          idx,
        input logic [PREG_NUM-1:0]        rdy,
        input logic [WAKE_NUM-1:0]        wv,
        input logic [WAKE_NUM*PREG_W-1:0] wp
    );
        logic hit;
        if ({1'b0, idx} >= PREG_LIMIT) begin
            hit = 1'b1;
        end else begin
            hit = rdy[idx];
            for (int k = 0; k < WAKE_NUM; k++) begin
                if (wv[k] && (wp[k*PREG_W +: PREG_W] == idx)) begin
                    hit = 1'b1;
                end
            end
        end
        return hit;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_lane
            assign v1[gi] = lookup(psrc1[gi*PREG_W +: PREG_W], r_ready, wake_valid, wake_preg);
            assign v2[gi] = lookup(psrc2[gi*PREG_W +: PREG_W], r_ready, wake_valid, wake_preg);
        end

        for (gi = 0; gi < PREG_NUM; gi++) begin : g_entry
            localparam logic [PREG_W-1:0] P_IDX = PREG_W'(gi);
            logic w_alloc_hit;
            logic w_wake_hit;

            always_comb begin
                w_alloc_hit = 1'b0;
                w_wake_hit  = 1'b0;
                for (int i = 0; i < FETCH_WIDTH; i++) begin
                    if (alloc_valid[i] && (alloc_preg[i*PREG_W +: PREG_W] == P_IDX)) begin
                        w_alloc_hit = 1'b1;
                    end
                end
                for (int k = 0; k < WAKE_NUM; k++) begin
                    if (wake_valid[k] && (wake_preg[k*PREG_W +: PREG_W] == P_IDX)) begin
                        w_wake_hit = 1'b1;
                    end
                end
            end

            // A new producer beats a stale wake of the same preg; flush beats both.
            assign w_ready_next[gi] = flush       ? 1'b1 :
                                      w_alloc_hit ? 1'b0 :
                                      w_wake_hit  ? 1'b1 : r_ready[gi];
        end
    endgenerate

    always_comb begin
        w_busy_next = '0;
        for (int p = 0; p < PREG_NUM; p++) begin
            w_busy_next = w_busy_next + {{PREG_W{1'b0}}, ~w_ready_next[p]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready    <= '1;
            r_busy_cnt <= '0;
        end else begin
            r_ready    <= w_ready_next;
            r_busy_cnt <= w_busy_next;
        end
    end

    assign busy_cnt = r_busy_cnt;

endmodule

// File: tb/tb_preg_ready_table.sv
// Bench for preg_ready_table: directed scenarios plus random traffic, all
// compared against a set-based readiness model kept here.
module tb_preg_ready_table;

    localparam int FW = 2;
    localparam int WN = 2;
    localparam int PN = 64;
    localparam int PW = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic [FW-1:0]     alloc_valid;
    logic [FW*PW-1:0]  alloc_preg;
    logic [WN-1:0]     wake_valid;
    logic [WN*PW-1:0]  wake_preg;
    logic              flush;
    logic [FW*PW-1:0]  psrc1;
    logic [FW*PW-1:0]  psrc2;
    logic [FW-1:0]     v1;
    logic [FW-1:0]     v2;
    logic [PW:0]       busy_cnt;

    preg_ready_table #(.FETCH_WIDTH(FW), .WAKE_NUM(WN), .PREG_NUM(PN), .PREG_W(PW)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_preg(alloc_preg),
        .wake_valid(wake_valid), .wake_preg(wake_preg),
        .flush(flush), .psrc1(psrc1), .psrc2(psrc2),
        .v1(v1), .v2(v2), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    bit model_rdy[PN];
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit model_query(input logic [PW-1:0] idx);
        bit r;
        r = model_rdy[idx];
        for (int k = 0; k < WN; k++)
            if (wake_valid[k] && wake_preg[k*PW +: PW] == idx) r = 1'b1;
        return r;
    endfunction

    function automatic int model_busy();
        int c = 0;
        for (int p = 0; p < PN; p++) if (!model_rdy[p]) c++;
        return c;
    endfunction

    task automatic idle();
        reset = 1'b0; flush = 1'b0;
        alloc_valid = '0; alloc_preg = '0;
        wake_valid = '0; wake_preg = '0;
        psrc1 = '0; psrc2 = '0;
    endtask

    task automatic set_alloc(input int lane, input int p);
        alloc_valid[lane] = 1'b1;
        alloc_preg[lane*PW +: PW] = PW'(p);
    endtask

    task automatic set_wake(input int port, input int p);
        wake_valid[port] = 1'b1;
        wake_preg[port*PW +: PW] = PW'(p);
    endtask

    task automatic set_q(input int lane, input int p1, input int p2);
        psrc1[lane*PW +: PW] = PW'(p1);
        psrc2[lane*PW +: PW] = PW'(p2);
    endtask

    // Waits to the falling edge, then compares queries and count with the model.
    task automatic check_all(input string tag);
        logic [FW-1:0] e1, e2;
        @(negedge clk);
        for (int i = 0; i < FW; i++) begin
            e1[i] = model_query(psrc1[i*PW +: PW]);
            e2[i] = model_query(psrc2[i*PW +: PW]);
        end
        chk({tag, ".v1"}, int'(v1), int'(e1));
        chk({tag, ".v2"}, int'(v2), int'(e2));
        chk({tag, ".busy"}, int'(busy_cnt), model_busy());
        $display("vec %0d %s alloc=%b/%h wake=%b/%h fl=%b rst=%b v1=%b v2=%b busy=%0d",
                 n_vec, tag, alloc_valid, alloc_preg, wake_valid, wake_preg,
                 flush, reset, v1, v2, busy_cnt);
    endtask

    // Clock edge: apply the same inputs to the model (wakes first, then allocs win).
    task automatic tick();
        @(posedge clk);
        if (reset || flush) begin
            for (int p = 0; p < PN; p++) model_rdy[p] = 1'b1;
        end else begin
            for (int k = 0; k < WN; k++)
                if (wake_valid[k]) model_rdy[wake_preg[k*PW +: PW]] = 1'b1;
            for (int i = 0; i < FW; i++)
                if (alloc_valid[i]) model_rdy[alloc_preg[i*PW +: PW]] = 1'b0;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int b0;
        idle();
        reset = 1'b1;
        tick();

        // Reset state
        idle(); set_q(0, 5, 0); set_q(1, 63, 1);
        check_all("t1");
        chk("t1.v1_const", int'(v1), 3);
        chk("t1.busy_const", int'(busy_cnt), 0);
        tick();

        // Alloc, then wake with bypass
        idle(); set_alloc(0, 10); set_alloc(1, 63);
        check_all("t2.alloc"); tick();
        idle(); set_q(0, 10, 10); set_q(1, 63, 63);
        check_all("t2.busy");
        chk("t2.v1_const", int'(v1), 0);
        chk("t2.busy_const", int'(busy_cnt), 2);
        tick();
        set_wake(1, 63);
        check_all("t2.bypass");
        chk("t2.bypass_const", int'(v1), 2);
        tick();
        idle(); set_q(0, 10, 10); set_q(1, 63, 63);
        check_all("t2.woken");
        chk("t2.woken_busy", int'(busy_cnt), 1);
        tick();

        // Alloc beats same-cycle wake; duplicate alloc counts once
        b0 = model_busy();
        idle(); set_alloc(0, 7); set_wake(0, 7);
        check_all("t3.aw"); tick();
        idle(); set_q(0, 7, 7); set_alloc(0, 20); set_alloc(1, 20);
        check_all("t3.dup");
        chk("t3.v1_7", int'(v1[0]), 0);
        chk("t3.busy_aw", int'(busy_cnt), b0 + 1);
        tick();
        idle();
        check_all("t3.after");
        chk("t3.busy_dup", int'(busy_cnt), b0 + 2);
        tick();

        // Flush overrides same-cycle alloc and wake
        idle(); set_alloc(0, 3); set_alloc(1, 4);
        check_all("t4.a"); tick();
        idle(); set_alloc(0, 5);
        check_all("t4.b"); tick();
        idle(); flush = 1'b1; set_alloc(0, 9); set_wake(0, 3);
        check_all("t4.flush"); tick();
        idle(); set_q(0, 3, 4); set_q(1, 9, 5);
        check_all("t4.post");
        chk("t4.v1", int'(v1), 3);
        chk("t4.v2", int'(v2), 3);
        chk("t4.busy", int'(busy_cnt), 0);
        tick();

        // Fill every entry, then drain two per cycle
        for (int c = 0; c < PN / 2; c++) begin
            idle(); set_alloc(0, 2 * c); set_alloc(1, 2 * c + 1);
            check_all("t5.fill"); tick();
        end
        for (int c = 0; c < PN / 2; c++) begin
            idle(); set_wake(0, 2 * c); set_wake(1, 2 * c + 1);
            check_all("t5.drain");
            chk("t5.busy", int'(busy_cnt), PN - 2 * c);
            tick();
        end
        idle();
        check_all("t5.empty");
        chk("t5.busy_zero", int'(busy_cnt), 0);
        tick();

        // Reset overrides alloc/wake but the query bypass still works
        idle(); set_alloc(0, 1); set_alloc(1, 2);
        check_all("t6.a"); tick();
        idle(); reset = 1'b1; set_wake(0, 1); set_alloc(0, 30); set_q(0, 2, 1);
        check_all("t6.rst");
        chk("t6.v2_bypass", int'(v2[0]), 1);
        chk("t6.v1_busy", int'(v1[0]), 0);
        tick();
        idle(); set_q(0, 30, 1); set_q(1, 2, 2);
        check_all("t6.post");
        chk("t6.busy", int'(busy_cnt), 0);
        tick();

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            idle();
            reset = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 49) == 0);
            alloc_valid = FW'($urandom);
            wake_valid  = WN'($urandom);
            for (int i = 0; i < FW; i++) begin
                alloc_preg[i*PW +: PW] = PW'($urandom);
                psrc1[i*PW +: PW] = PW'($urandom);
                psrc2[i*PW +: PW] = PW'($urandom);
            end
            for (int k = 0; k < WN; k++) begin
                wake_preg[k*PW +: PW] = ($urandom_range(0, 1) == 1) ? psrc1[k*PW +: PW]
                                                                    : PW'($urandom);
            end
            check_all("rnd");
            tick();
        end
        idle();
        check_all("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
